// File: rtl/div_controller_pkg.sv
// Shared definitions for the iterative DIV/DIVU unit: funct codes, FSM state
// encodings and the default datapath width.
package div_controller_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [5:0] FUNCT_DIV  = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU = 6'h1b;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_controller_step.sv
// One restoring shift-subtract iteration: shift {rem,quo} left, trial-subtract
// the divisor from the widened remainder and keep the difference if no borrow.
module div_step
  import div_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  // One extra bit so a shifted remainder >= 2**WIDTH still compares correctly.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign borrow   = diff[WIDTH];
  assign rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_controller.sv
// DIV/DIVU sequencer: latches operand magnitudes, runs WIDTH restoring steps,
// applies signs and commits quotient to LO and remainder to HI.
module div_controller
  import div_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  input  logic             read_hi,
  input  logic             read_lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  div_state_t state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rem_reg, quo_reg, dvsr_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             q_neg_reg, r_neg_reg, done_reg;

  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             load, step, commit;

  // Two's-complement negation of the most negative value wraps to itself,
  // which is exactly the unsigned magnitude we want.
  assign dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (dvsr_reg),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_reg == CNT_W'(1)) state_next = FIXUP;
        end
      end
      FIXUP: begin
        state_next = IDLE;
        commit     = !flush;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvsr_reg  <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= commit;
      if (load) begin
        cnt_reg   <= CNT_W'(WIDTH);
        rem_reg   <= '0;
        quo_reg   <= dividend_mag;
        dvsr_reg  <= divisor_mag;
        q_neg_reg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        r_neg_reg <= is_signed & dividend[WIDTH-1];
      end else if (step) begin
        cnt_reg <= cnt_reg - 1'b1;
        rem_reg <= rem_step;
        quo_reg <= quo_step;
      end
      if (commit) begin
        lo_reg <= q_neg_reg ? -quo_reg : quo_reg;
        hi_reg <= r_neg_reg ? -rem_reg : rem_reg;
      end
    end
  end

  assign busy  = (state_reg != IDLE);
  assign stall = busy & (read_hi | read_lo | start);
  assign done  = done_reg;
  assign hi    = hi_reg;
  assign lo    = lo_reg;

endmodule

// File: tb/tb_div_controller.sv
// Directed bench for div_controller: latency, signed/unsigned results, corner
// cases, stall behaviour, flush and asynchronous reset.
module tb_div_controller;

  logic        clock;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        read_hi;
  logic        read_lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  div_controller #(.WIDTH(32), .CNT_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .read_hi   (read_hi),
    .read_lo   (read_lo),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one divide, wait (bounded) for done, check latency, busy span and results.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    int cyc;
    int busy_cnt;
    bit seen;
    @(posedge clock); #1;
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else cyc++;
    end
    check({tag, "_latency"}, cyc, 33);
    check({tag, "_busy_cycles"}, busy_cnt, 33);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_hi"}, hi, exp_hi);
    $display("div %s signed=%0d a=%h b=%h -> lo=%h hi=%h cycles=%0d", tag, sgn, a, b, lo, hi, cyc);
    @(negedge clock);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int dc;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    flush = 1'b0; read_hi = 1'b0; read_lo = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_stall", stall, 0);
    reset = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

    // MFHI held from cycle 2, a second divide presented at cycle 5.
    @(posedge clock); #1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k <= 33; k++) begin
      if (k == 2) read_hi = 1'b1;
      if (k == 5) begin start = 1'b1; dividend = 32'd50; divisor = 32'd5; end
      if (k == 6) start = 1'b0;
      @(negedge clock);
      check($sformatf("stall_c%0d", k), stall, (k >= 2 && k <= 32) ? 32'd1 : 32'd0);
      if (k == 33) begin
        check("stall_done", done, 1);
        check("stall_hi_new", hi, 2);
        check("stall_lo_new", lo, 14);
      end
      @(posedge clock); #1;
    end
    read_hi = 1'b0;
    $display("stall sequence lo=%h hi=%h", lo, hi);

    // Flush mid-RUN keeps previous HI/LO.
    run_div("divu_19_4", 1'b0, 32'd19, 32'd4, 32'd4, 32'd3);
    @(posedge clock); #1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(negedge clock);
    check("flush_busy_before", busy, 1);
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    check("flush_busy_after", busy, 0);
    dc = 0;
    repeat (40) begin @(negedge clock); if (done) dc++; end
    check("flush_no_done", dc, 0);
    check("flush_hi", hi, 3);
    check("flush_lo", lo, 4);
    $display("flush mid-run lo=%h hi=%h", lo, hi);

    // start and flush together in IDLE: nothing starts.
    @(posedge clock); #1;
    start = 1'b1; flush = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clock);
    check("sf_busy", busy, 0);
    dc = 0;
    repeat (35) begin @(negedge clock); if (done || busy) dc++; end
    check("sf_idle", dc, 0);
    check("sf_lo", lo, 4);
    $display("start+flush in idle busy=%0d lo=%h", busy, lo);

    // Asynchronous reset in the middle of RUN.
    @(posedge clock); #1;
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    $display("async reset busy=%0d hi=%h lo=%h", busy, hi, lo);
    @(posedge clock); #1;
    reset = 1'b0;
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_controller.md
Name: div_controller

Overview:
Sequences the multi-cycle iterative divider behind the DIV/DIVU instructions and owns the HI/LO architectural registers. It sits beside the execute stage and accepts a divide issue from the pipeline. It runs a restoring shift-subtract loop one bit per cycle and commits the quotient to LO and the remainder to HI. It raises a stall to the hazard logic whenever a dependent MFHI/MFLO, or a second divide, reaches execute while the loop is running.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.
CNT_W, 6, width of iteration counter; must satisfy 2**CNT_W > WIDTH.

Ports:
clock  in  1  single system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
start  in  1  execute stage issues DIV/DIVU this cycle.
is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start.
dividend  in  WIDTH  rs value; sampled with start.
divisor  in  WIDTH  rt value; sampled with start.
flush  in  1  pipeline squash; aborts an in-flight divide.
read_hi  in  1  MFHI in execute this cycle.
read_lo  in  1  MFLO in execute this cycle.
busy  out  1  loop active (RUN or FIXUP).
stall  out  1  combinational hold request to hazard unit.
done  out  1  one-cycle pulse when HI/LO are committed.
hi  out  WIDTH  HI register (remainder).
lo  out  WIDTH  LO register (quotient).

Behaviour:
- Reset (async, active-high): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal shift registers=0.
- States:
  - IDLE: on start & ~flush, latch the operand magnitudes (two's-complement absolute value when is_signed, raw otherwise). Latch quotient sign = sign(dividend)^sign(divisor) and remainder sign = sign(dividend), both only when is_signed. Set counter=WIDTH and go to RUN.
  - RUN: each cycle shift {rem,quo} left by 1 and trial-subtract the divisor from rem. On non-negative result, keep the difference and set quo[0]=1. Decrement the counter; when it reaches 1 this cycle, go to FIXUP.
  - FIXUP: apply signs (negate quo/rem if their sign flag is set). Write lo=quo and hi=rem, pulse done=1, go to IDLE.
- Latency: start sampled at edge N; done=1 and new hi/lo visible after edge N+WIDTH+1 (33 cycles for WIDTH=32). busy=1 from after edge N through FIXUP inclusive.
- Results: hi/lo change only on the FIXUP edge; otherwise they hold.
- Width rule: the trial subtract is WIDTH+1 bits wide so a borrow is detected. Negation of 0x80000000 yields 0x80000000, treated as an unsigned magnitude.
- Divide by zero (divisor==0): not trapped. The loop runs its normal length. Result is lo=all ones and hi=dividend magnitude (DIVU), then sign-fixup as normal (DIV). No early exit.
- Overflow (DIV -2^31 / -1): lo=0x80000000, hi=0. No exception.
- stall = busy & (read_hi | read_lo | start). stall is 0 in IDLE, including the FIXUP->IDLE cycle onward. MFHI in the cycle after done reads the new value.
- start while busy: ignored (operands not latched), stall=1; the pipeline re-presents the instruction.
- flush while RUN/FIXUP: next edge goes to IDLE, hi/lo unchanged, done stays 0.
- flush & start in the same cycle in IDLE: flush wins; no divide starts.
- reset mid-operation: immediate return to IDLE with hi=lo=0.

Decomposition:
- Shared header (alongside the opcode/funct defines):
  - DIV and DIVU funct codes.
  - State encodings IDLE=2'd0, RUN=2'd1, FIXUP=2'd2.
  - Default WIDTH.
- One natural sub-module, div_step: combinational single iteration. Inputs rem, quo, divisor; outputs next rem and next quo.
- div_controller holds the FSM, counter, sign flags and HI/LO registers.

Test Plan:
- DIVU 100/7: start at cycle 0 -> done pulse at cycle 33; lo=14, hi=2; busy high exactly 33 cycles.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- read_hi held from cycle 2 after start -> stall=1 every cycle through FIXUP, 0 the cycle after done; hi then shows the new remainder. A second start at cycle 5 is ignored with stall=1.
- flush at cycle 10 of a DIVU 100/7 with prior hi=3, lo=4 -> IDLE at next edge, no done, hi=3, lo=4; start+flush together in IDLE -> busy stays 0.
- reset asserted asynchronously mid-RUN -> busy, done, hi, lo go to 0 immediately without a clock edge; a fresh DIVU 9/3 afterwards gives lo=3, hi=0.
